// File: rtl/axi_lite_arb_pkg.sv
// Shared types and constants for the AXI4-Lite master arbiter.
package axi_lite_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      WR_RESP,
      RD,
      RD_DATA,
      RSP
   } state_e;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi_lite_master_arbiter_rr_arbiter.sv
// Round-robin grant selection: first requester above last_grant, wrapping to the lowest index.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_grant_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] grant_idx_o,
   output logic          any_grant_o
);

   logic [N-1:0] hi_mask;
   logic [N-1:0] pick;

   always_comb begin
      // NOTE: every output gets a default before any branch, so no path leaves a latch.
      hi_mask     = '0;
      grant_o     = '0;
      grant_idx_o = '0;
      for (int i = 0; i < N; i++) begin
         hi_mask[i] = (IW'(i) > last_grant_i);
      end
      // Requesters above the last winner go first; if none, wrap to the full set.
      pick = (|(req_i & hi_mask)) ? (req_i & hi_mask) : req_i;
      for (int i = N - 1; i >= 0; i--) begin
         if (pick[i]) begin
            grant_o     = '0;
            grant_o[i]  = 1'b1;
            grant_idx_o = IW'(i);
         end
      end
      any_grant_o = |req_i;
   end

endmodule

// File: rtl/axi_lite_master_arbiter.sv
// Shares one AXI4-Lite master port between NUM_REQ requesters, one transaction at a time,
// granting round-robin and returning read data / response codes to the winner.
module axi_lite_master_arbiter
   import axi_lite_arb_pkg::*;
#(
   parameter int NUM_REQ          = 4,
   parameter int M_AXI_DATA_WIDTH = 32,
   parameter int M_AXI_ADDR_WIDTH = 32
) (
   input  logic                                 M_AXI_ACLK,
   input  logic                                 M_AXI_ARESET,
   input  logic [NUM_REQ-1:0]                   req_valid,
   input  logic [NUM_REQ-1:0]                   req_write,
   input  logic [NUM_REQ*M_AXI_ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ*M_AXI_DATA_WIDTH-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]                   req_ready,
   output logic [NUM_REQ-1:0]                   rsp_valid,
   output logic [M_AXI_DATA_WIDTH-1:0]          rsp_rdata,
   output logic [1:0]                           rsp_resp,
   output logic                                 busy,
   output logic                                 M_AXI_AWVALID,
   input  logic                                 M_AXI_AWREADY,
   output logic [M_AXI_ADDR_WIDTH-1:0]          M_AXI_AWADDR,
   output logic [2:0]                           M_AXI_AWPROT,
   output logic                                 M_AXI_WVALID,
   input  logic                                 M_AXI_WREADY,
   output logic [M_AXI_DATA_WIDTH-1:0]          M_AXI_WDATA,
   output logic [M_AXI_DATA_WIDTH/8-1:0]        M_AXI_WSTRB,
   input  logic                                 M_AXI_BVALID,
   output logic                                 M_AXI_BREADY,
   input  logic [1:0]                           M_AXI_BRESP,
   output logic                                 M_AXI_ARVALID,
   input  logic                                 M_AXI_ARREADY,
   output logic [M_AXI_ADDR_WIDTH-1:0]          M_AXI_ARADDR,
   output logic [2:0]                           M_AXI_ARPROT,
   input  logic                                 M_AXI_RVALID,
   output logic                                 M_AXI_RREADY,
   input  logic [M_AXI_DATA_WIDTH-1:0]          M_AXI_RDATA,
   input  logic [1:0]                           M_AXI_RRESP
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_e                        state_q, state_d;
   logic [IW-1:0]                 last_grant_q, last_grant_d;
   logic [IW-1:0]                 grant_idx_q, grant_idx_d;
   logic [M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [M_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]                    resp_q, resp_d;
   logic                          awvalid_q, awvalid_d;
   logic                          wvalid_q, wvalid_d;
   logic                          bready_q, bready_d;
   logic                          arvalid_q, arvalid_d;
   logic                          rready_q, rready_d;

   logic [NUM_REQ-1:0]            arb_grant;
   logic [IW-1:0]                 arb_idx;
   logic                          arb_any;

   rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
      .req_i        (req_valid),
      .last_grant_i (last_grant_q),
      .grant_o      (arb_grant),
      .grant_idx_o  (arb_idx),
      .any_grant_o  (arb_any)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_idx_d  = grant_idx_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      resp_d       = resp_q;
      awvalid_d    = awvalid_q;
      wvalid_d     = wvalid_q;
      bready_d     = bready_q;
      arvalid_d    = arvalid_q;
      rready_d     = rready_q;
      req_ready    = '0;
      rsp_valid    = '0;

      case (state_q)
         IDLE: begin
            if (arb_any) begin
               req_ready   = arb_grant;
               grant_idx_d = arb_idx;
               addr_d      = req_addr[int'(arb_idx)*M_AXI_ADDR_WIDTH +: M_AXI_ADDR_WIDTH];
               wdata_d     = req_wdata[int'(arb_idx)*M_AXI_DATA_WIDTH +: M_AXI_DATA_WIDTH];
               if (req_write[arb_idx]) begin
                  state_d   = WR;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = RD;
                  arvalid_d = 1'b1;
               end
            end
         end
         WR: begin
            // AW and W complete independently; leave only once both have handshaken.
            if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
            if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               state_d  = WR_RESP;
               bready_d = 1'b1;
            end
         end
         WR_RESP: begin
            if (M_AXI_BVALID) begin
               resp_d   = M_AXI_BRESP;
               rdata_d  = '0;
               bready_d = 1'b0;
               state_d  = RSP;
            end
         end
         RD: begin
            if (M_AXI_ARREADY) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_DATA;
            end
         end
         RD_DATA: begin
            if (M_AXI_RVALID) begin
               rdata_d  = M_AXI_RDATA;
               resp_d   = M_AXI_RRESP;
               rready_d = 1'b0;
               state_d  = RSP;
            end
         end
         RSP: begin
            rsp_valid[grant_idx_q] = 1'b1;
            last_grant_d           = grant_idx_q;
            state_d                = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
      // NOTE: non-blocking assignments so every register samples the pre-edge value of the others.
      if (M_AXI_ARESET) begin
         state_q      <= IDLE;
         last_grant_q <= IW'(NUM_REQ - 1);
         grant_idx_q  <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         resp_q       <= AXI_RESP_OKAY;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         bready_q     <= 1'b0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_idx_q  <= grant_idx_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         resp_q       <= resp_d;
         awvalid_q    <= awvalid_d;
         wvalid_q     <= wvalid_d;
         bready_q     <= bready_d;
         arvalid_q    <= arvalid_d;
         rready_q     <= rready_d;
      end
   end

   assign busy          = (state_q != IDLE);
   assign rsp_rdata     = rdata_q;
   assign rsp_resp      = resp_q;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_AWPROT  = AXI_PROT_DEFAULT;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = '1;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARPROT  = AXI_PROT_DEFAULT;
   assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// Directed bench: table of single transactions against a configurable-latency slave,
// plus hand-written sequences for round-robin order, AW/W skew and reset mid-read.
module tb_axi_lite_master_arbiter;

   localparam int NR = 4;
   localparam int DW = 32;
   localparam int AW = 32;

   typedef struct {
      bit          write;
      int          idx;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          aw_dly;
      int          w_dly;
      int          b_dly;
      int          ar_dly;
      int          r_dly;
      logic [31:0] s_rdata;
      logic [1:0]  s_resp;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
      int          exp_lat;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR-1:0]    req_valid, req_write;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_wdata;
   logic [NR-1:0]    req_ready, rsp_valid;
   logic [DW-1:0]    rsp_rdata;
   logic [1:0]       rsp_resp;
   logic             busy;
   logic             awvalid, awready, wvalid, wready, bvalid, bready;
   logic             arvalid, arready, rvalid, rready;
   logic [AW-1:0]    awaddr, araddr;
   logic [DW-1:0]    wdata, rdata;
   logic [DW/8-1:0]  wstrb;
   logic [2:0]       awprot, arprot;
   logic [1:0]       bresp, rresp;

   int n_checks = 0;
   int n_fail   = 0;

   // slave configuration (written by the stimulus thread)
   int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
   logic [31:0] cfg_rdata = '0;
   logic [1:0]  cfg_resp  = '0;

   // monitor logs (written by the slave/monitor thread)
   int          cyc = 0;
   int          n_grant = 0, n_rsp = 0, oh_bad = 0;
   int          last_grant_idx = -1, last_grant_cyc = 0;
   int          last_rsp_idx = -1, last_rsp_cyc = 0;
   logic [31:0] last_rsp_rdata;
   logic [1:0]  last_rsp_resp;
   logic [31:0] log_awaddr, log_wdata, log_araddr;
   logic [3:0]  log_wstrb;
   int          grant_hist[$];
   int          gcyc_hist[$];

   initial forever #5 clk = ~clk;

   axi_lite_master_arbiter #(
      .NUM_REQ(NR), .M_AXI_DATA_WIDTH(DW), .M_AXI_ADDR_WIDTH(AW)
   ) dut (
      .M_AXI_ACLK(clk),        .M_AXI_ARESET(rst),
      .req_valid(req_valid),   .req_write(req_write),
      .req_addr(req_addr),     .req_wdata(req_wdata),
      .req_ready(req_ready),   .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),   .rsp_resp(rsp_resp),     .busy(busy),
      .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready), .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot),
      .M_AXI_WVALID(wvalid),   .M_AXI_WREADY(wready),   .M_AXI_WDATA(wdata),   .M_AXI_WSTRB(wstrb),
      .M_AXI_BVALID(bvalid),   .M_AXI_BREADY(bready),   .M_AXI_BRESP(bresp),
      .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready), .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot),
      .M_AXI_RVALID(rvalid),   .M_AXI_RREADY(rready),   .M_AXI_RDATA(rdata),   .M_AXI_RRESP(rresp)
   );

   // Slave model and monitor: acts on the falling edge, away from the DUT's active edge.
   initial begin : slave
      int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
      bit aw_got, w_got, ar_got;
      logic pv_aw, pv_w, pv_b, pv_ar, pv_r;
      logic [31:0] pv_awaddr, pv_wdata, pv_araddr;
      logic [3:0]  pv_wstrb;
      {awready, wready, bvalid, arready, rvalid} = '0;
      bresp = '0; rresp = '0; rdata = '0;
      {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} = '0;
      {aw_got, w_got, ar_got} = '0;
      {pv_aw, pv_w, pv_b, pv_ar, pv_r} = '0;
      pv_awaddr = '0; pv_wdata = '0; pv_araddr = '0; pv_wstrb = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            {awready, wready, bvalid, arready, rvalid} = '0;
            {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} = '0;
            {aw_got, w_got, ar_got} = '0;
            {pv_aw, pv_w, pv_b, pv_ar, pv_r} = '0;
         end else begin
            if (pv_aw && awready) begin aw_got = 1; log_awaddr = pv_awaddr; end
            if (pv_w && wready) begin w_got = 1; log_wdata = pv_wdata; log_wstrb = pv_wstrb; end
            if (pv_ar && arready) begin ar_got = 1; log_araddr = pv_araddr; end
            if (pv_b && bvalid) begin bvalid = 0; aw_got = 0; w_got = 0; b_cnt = 0; end
            if (pv_r && rvalid) begin rvalid = 0; ar_got = 0; r_cnt = 0; end
            if (awvalid) begin awready = (aw_cnt >= cfg_aw_dly); aw_cnt++; end
            else begin awready = 0; aw_cnt = 0; end
            if (wvalid) begin wready = (w_cnt >= cfg_w_dly); w_cnt++; end
            else begin wready = 0; w_cnt = 0; end
            if (arvalid) begin arready = (ar_cnt >= cfg_ar_dly); ar_cnt++; end
            else begin arready = 0; ar_cnt = 0; end
            if (aw_got && w_got && !bvalid) begin
               if (b_cnt >= cfg_b_dly) begin bvalid = 1; bresp = cfg_resp; end
               else b_cnt++;
            end
            if (ar_got && !rvalid) begin
               if (r_cnt >= cfg_r_dly) begin rvalid = 1; rdata = cfg_rdata; rresp = cfg_resp; end
               else r_cnt++;
            end
            pv_aw = awvalid; pv_w = wvalid; pv_b = bready; pv_ar = arvalid; pv_r = rready;
            pv_awaddr = awaddr; pv_wdata = wdata; pv_wstrb = wstrb; pv_araddr = araddr;
         end
         if (!$onehot0(req_ready)) oh_bad++;
         if (!$onehot0(rsp_valid)) oh_bad++;
         if (|req_ready) begin
            n_grant++;
            last_grant_cyc = cyc;
            for (int i = 0; i < NR; i++) if (req_ready[i]) last_grant_idx = i;
            grant_hist.push_back(last_grant_idx);
            gcyc_hist.push_back(cyc);
         end
         if (|rsp_valid) begin
            n_rsp++;
            last_rsp_cyc   = cyc;
            last_rsp_rdata = rsp_rdata;
            last_rsp_resp  = rsp_resp;
            for (int i = 0; i < NR; i++) if (rsp_valid[i]) last_rsp_idx = i;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic set_slave(input vec_t v);
      cfg_aw_dly = v.aw_dly; cfg_w_dly = v.w_dly; cfg_b_dly = v.b_dly;
      cfg_ar_dly = v.ar_dly; cfg_r_dly = v.r_dly;
      cfg_rdata  = v.s_rdata; cfg_resp = v.s_resp;
   endtask

   task automatic wait_grant(input int g0, output bit got);
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         tick(1);
         if (n_grant > g0) got = 1;
      end
   endtask

   task automatic wait_rsp(input int r0, output bit got);
      got = 0;
      for (int c = 0; c < 40 && !got; c++) begin
         tick(1);
         if (n_rsp > r0) got = 1;
      end
   endtask

   task automatic run_txn(input string tag, input vec_t v);
      int g0, r0;
      bit got;
      set_slave(v);
      req_write[v.idx]             = v.write;
      req_addr[v.idx*AW +: AW]     = v.addr;
      req_wdata[v.idx*DW +: DW]    = v.wdata;
      g0 = n_grant; r0 = n_rsp;
      req_valid[v.idx] = 1'b1;
      wait_grant(g0, got);
      req_valid = '0;
      check({tag, "_grant_seen"}, got, 1);
      if (!got) return;
      wait_rsp(r0, got);
      check({tag, "_rsp_seen"}, got, 1);
      if (!got) return;
      tick(2);
      check({tag, "_grant_idx"}, last_grant_idx, v.idx);
      check({tag, "_rsp_idx"}, last_rsp_idx, v.idx);
      check({tag, "_rsp_pulses"}, n_rsp, r0 + 1);
      check({tag, "_latency"}, last_rsp_cyc - last_grant_cyc, v.exp_lat);
      check({tag, "_rsp_rdata"}, last_rsp_rdata, v.exp_rdata);
      check({tag, "_rsp_resp"}, last_rsp_resp, v.exp_resp);
      if (v.write) begin
         check({tag, "_awaddr"}, log_awaddr, v.addr);
         check({tag, "_wdata"}, log_wdata, v.wdata);
         check({tag, "_wstrb"}, log_wstrb, 4'hF);
      end else begin
         check({tag, "_araddr"}, log_araddr, v.addr);
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      vec_t vecs[6];
      vec_t pre;
      logic awv[1:9], wv[1:9], br[1:9];
      logic aw_hold, br_early;
      int   exp_rr[6];
      int   g0, r0, h0;
      bit   got;

      // write/read, requester, addr, wdata, aw/w/b/ar/r delays, slave rdata, slave resp,
      // expected rsp_rdata, expected rsp_resp, expected grant-to-rsp latency
      vecs[0] = '{1'b1, 1, 32'h4000_0010, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 32'h0,         2'b00, 32'h0,         2'b00, 3};
      vecs[1] = '{1'b0, 0, 32'h4000_0004, 32'h0,         0, 0, 0, 0, 5, 32'h1234_5678, 2'b00, 32'h1234_5678, 2'b00, 8};
      vecs[2] = '{1'b1, 2, 32'h4000_0020, 32'hCAFE_F00D, 0, 0, 2, 0, 0, 32'h0,         2'b10, 32'h0,         2'b10, 5};
      vecs[3] = '{1'b0, 3, 32'h4000_0100, 32'h0,         0, 0, 0, 0, 0, 32'hA5A5_5A5A, 2'b10, 32'hA5A5_5A5A, 2'b10, 3};
      vecs[4] = '{1'b0, 1, 32'h4000_0008, 32'h0,         0, 0, 0, 3, 0, 32'h0BAD_F00D, 2'b00, 32'h0BAD_F00D, 2'b00, 6};
      vecs[5] = '{1'b1, 0, 32'h4000_0030, 32'h1111_2222, 2, 4, 0, 0, 0, 32'h0,         2'b11, 32'h0,         2'b11, 7};
      exp_rr = '{0, 1, 3, 0, 1, 3};

      rst = 1'b1;
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      tick(3);
      check("rst_busy", busy, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_awvalid", awvalid, 0);
      check("rst_wvalid", wvalid, 0);
      check("rst_bready", bready, 0);
      check("rst_arvalid", arvalid, 0);
      check("rst_rready", rready, 0);
      check("rst_awaddr", awaddr, 0);
      check("rst_araddr", araddr, 0);
      check("rst_wdata", wdata, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_resp", rsp_resp, 0);
      check("awprot", awprot, 0);
      check("arprot", arprot, 0);
      check("wstrb", wstrb, 4'hF);
      rst = 1'b0;
      tick(2);

      for (int i = 0; i < 6; i++) begin
         run_txn($sformatf("vec%0d", i), vecs[i]);
         tick(1);
      end

      // Write with W accepted at once and AW held off until cycle 6.
      cfg_aw_dly = 5; cfg_w_dly = 0; cfg_b_dly = 0; cfg_resp = 2'b00;
      req_write[2] = 1'b1;
      req_addr[2*AW +: AW]  = 32'h4000_0040;
      req_wdata[2*DW +: DW] = 32'h5555_AAAA;
      r0 = n_rsp;
      req_valid = 4'b0100;
      for (int k = 1; k <= 9; k++) begin
         tick(1);
         if (k == 1) req_valid = '0;
         awv[k] = awvalid; wv[k] = wvalid; br[k] = bready;
         if (k == 3) check("skew_busy", busy, 1);
      end
      aw_hold = 1'b1; br_early = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         aw_hold  = aw_hold & awv[k];
         br_early = br_early | br[k];
      end
      check("skew_wvalid_c1", wv[1], 1);
      check("skew_wvalid_c2", wv[2], 0);
      check("skew_awvalid_held", aw_hold, 1);
      check("skew_bready_early", br_early, 0);
      check("skew_awvalid_c7", awv[7], 0);
      check("skew_bready_c7", br[7], 1);
      check("skew_rsp_count", n_rsp, r0 + 1);
      check("skew_latency", last_rsp_cyc - last_grant_cyc, 8);
      check("skew_rsp_idx", last_rsp_idx, 2);
      check("skew_awaddr", log_awaddr, 32'h4000_0040);

      // Round-robin with three requesters held continuously after reset.
      rst = 1'b1; tick(2); rst = 1'b0; tick(1);
      cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 0; cfg_ar_dly = 0; cfg_r_dly = 0;
      cfg_resp = 2'b00; cfg_rdata = 32'h0000_0042;
      req_write = '0;
      req_addr[0*AW +: AW] = 32'h4000_1000;
      req_addr[1*AW +: AW] = 32'h4000_1004;
      req_addr[3*AW +: AW] = 32'h4000_100C;
      h0 = grant_hist.size();
      req_valid = 4'b1011;
      for (int c = 0; c < 60 && grant_hist.size() < h0 + 6; c++) tick(1);
      req_valid = '0;
      check("rr_grants_seen", grant_hist.size() >= h0 + 6, 1);
      for (int k = 0; k < 6; k++) begin
         check($sformatf("rr_grant%0d", k),
               (h0 + k < grant_hist.size()) ? grant_hist[h0 + k] : -1, exp_rr[k]);
      end
      check("rr_interval", (h0 + 5 < gcyc_hist.size()) ? gcyc_hist[h0 + 5] - gcyc_hist[h0] : -1, 20);
      tick(6);
      check("rr_idle_after", busy, 0);

      // Reset while waiting for read data: no response, priority back to requester 0.
      pre = '{1'b0, 0, 32'h4000_0050, 32'h0, 0, 0, 0, 0, 0, 32'h7777_0000, 2'b00, 32'h7777_0000, 2'b00, 3};
      run_txn("pre", pre);
      tick(1);
      cfg_r_dly = 10;
      req_write = '0;
      req_addr[0*AW +: AW] = 32'h4000_0054;
      req_addr[1*AW +: AW] = 32'h4000_0058;
      r0 = n_rsp;
      req_valid = 4'b0001;
      tick(1);
      req_valid = '0;
      tick(1);
      check("abort_rready_before", rready, 1);
      rst = 1'b1;
      #1;
      check("abort_handshake_sigs", {awvalid, wvalid, bready, arvalid, rready}, 0);
      check("abort_busy", busy, 0);
      tick(2);
      rst = 1'b0;
      tick(12);
      check("abort_no_rsp", n_rsp, r0);
      cfg_r_dly = 0;
      g0 = n_grant; r0 = n_rsp;
      req_valid = 4'b0011;
      wait_grant(g0, got);
      req_valid = '0;
      check("abort_regrant_seen", got, 1);
      check("abort_regrant_idx", last_grant_idx, 0);
      wait_rsp(r0, got);
      check("abort_regrant_rsp_seen", got, 1);
      check("abort_regrant_rsp_idx", last_rsp_idx, 0);
      tick(2);

      check("onehot_violations", oh_bad, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_lite_master_arbiter.md
Name: axi_lite_master_arbiter

Overview:
Shares one AXI4-Lite general-purpose master port between NUM_REQ on-chip requesters, such as the CSR sequencer, DMA descriptor loader and debug bridge.
Each requester issues single 32-bit register reads or writes over a simple valid/ready request and response interface.
The block arbitrates round-robin, runs exactly one AXI-Lite transaction at a time, and returns read data and response codes to the winning requester.
It sits between the accelerator control logic and the PS/interconnect slave port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
M_AXI_DATA_WIDTH, 32, AXI data width
M_AXI_ADDR_WIDTH, 32, AXI address width

Ports:
M_AXI_ACLK  in  1  clock
M_AXI_ARESET  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request pending
req_write  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*M_AXI_ADDR_WIDTH  packed addresses, requester i at slice i
req_wdata  in  NUM_REQ*M_AXI_DATA_WIDTH  packed write data
req_ready  out  NUM_REQ  one-hot, one-cycle pulse: request accepted
rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse: transaction complete
rsp_rdata  out  M_AXI_DATA_WIDTH  read data, valid with rsp_valid; 0 for writes
rsp_resp  out  2  BRESP or RRESP, valid with rsp_valid
busy  out  1  high in every state except IDLE
M_AXI_AWVALID/AWREADY/AWADDR/AWPROT, M_AXI_WVALID/WREADY/WDATA/WSTRB, M_AXI_BVALID/BREADY/BRESP, M_AXI_ARVALID/ARREADY/ARADDR/ARPROT, M_AXI_RVALID/RREADY/RDATA/RRESP  standard AXI4-Lite master directions and widths

Behaviour:
- Reset (async assert, sync release) sets:
  - state = IDLE
  - all VALID/READY outputs and req_ready, rsp_valid, busy = 0
  - AWADDR/ARADDR/WDATA/rsp_rdata = 0, rsp_resp = 0
  - last_grant = NUM_REQ-1, so requester 0 has top priority after reset
- Constant outputs: AWPROT = ARPROT = 3'b000; WSTRB = all ones.
- FSM states: IDLE, WR, WR_RESP, RD, RD_DATA, RSP.
- IDLE:
  - If any req_valid is high, grant the first set bit scanning upward from last_grant+1 and wrapping modulo NUM_REQ.
  - Latch the winner's write flag, address and data into internal registers.
  - Pulse req_ready[g] in the same cycle, combinationally from req_valid and state.
  - Next state is WR or RD.
  - Requesters hold valid and payload until req_ready. A req_valid that drops before grant is ignored and causes no error.
- WR:
  - AWVALID and WVALID are both registered high on WR entry.
  - Each drops independently on the cycle after its own handshake (VALID & READY). Either may complete first, or both in the same cycle.
  - When both are done, go to WR_RESP with BREADY = 1.
  - VALID never deasserts before its handshake.
- WR_RESP: on BVALID & BREADY, capture BRESP, set rsp_rdata = 0, set BREADY = 0, go to RSP.
- RD:
  - ARVALID is registered high on RD entry.
  - On ARVALID & ARREADY, drop ARVALID and go to RD_DATA with RREADY = 1.
- RD_DATA: on RVALID & RREADY, capture RDATA and RRESP, set RREADY = 0, go to RSP.
- RSP:
  - rsp_valid[g] = 1 for exactly one cycle.
  - Update last_grant = g, return to IDLE.
  - A new grant is possible in the next cycle.
- Latency with zero-wait slave:
  - Write: grant at cycle 0, AW/W handshake cycle 1, B handshake cycle 2, rsp_valid cycle 3.
  - Read: same count (AR at 1, R at 2, rsp at 3).
  - Back-to-back throughput: one transaction per 4 cycles.
- Only one outstanding transaction at a time. No bursts and no ID reordering.
- rsp_resp SLVERR/DECERR is passed through unchanged; the block does not retry.
- Reset mid-transaction aborts immediately: outputs return to their reset values, the grant is lost, and the requester receives no rsp_valid.
- Simultaneous events:
  - A new req_valid arriving during a transaction waits until IDLE.
  - A requester may reassert req_valid in the same cycle its rsp_valid is high.

Decomposition:
- Package axi_lite_arb_pkg holds:
  - state enum (IDLE, WR, WR_RESP, RD, RD_DATA, RSP)
  - AXI_RESP_OKAY = 2'b00, AXI_RESP_SLVERR = 2'b10, AXI_RESP_DECERR = 2'b11
  - default PROT constant
- Sub-module rr_arbiter (parameter N) contains the priority mask and one-hot grant logic only.
  - Inputs: req vector, last_grant index.
  - Outputs: grant one-hot, grant index, any_grant.

Test Plan:
- Single write, requester 1, addr 0x4000_0010, data 0xDEADBEEF, zero-wait slave -> AWADDR/WDATA match; rsp_valid[1] pulse 3 cycles after req_ready[1]; rsp_resp = 0.
- Single read, requester 0, addr 0x4000_0004, slave returns 0x1234_5678 after 5-cycle RVALID delay -> rsp_rdata = 0x12345678, rsp_valid[0] exactly one cycle.
- req_valid = 4'b1011 held continuously after reset -> grant order 0, 1, 3, 0, 1, 3; no requester granted twice while another waits.
- Write with WREADY at cycle 1 and AWREADY delayed to cycle 6 -> WVALID drops at cycle 2, AWVALID stays high until handshake, BREADY asserts only after both complete.
- Read with slave RRESP = 2'b10 -> rsp_resp = 2'b10 delivered to the requester; FSM returns to IDLE; next request proceeds normally.
- Assert M_AXI_ARESET while in RD_DATA -> all AXI VALID/READY = 0 immediately; no rsp_valid; after release requester 0 is granted first.
